// File: rtl/baud_rate.sv
// Baud-rate strobe generator: Rxclk_en at OVERSAMPLE x baud, Txclk_en at 1 x baud, both on clk_50m.
// Optional macro BAUD_TX_LOCK_EN derives Txclk_en from every OVERSAMPLE-th receiver strobe.
module baud_rate #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk_50m,
    input  logic rst_n,
    output logic Rxclk_en,
    output logic Txclk_en
);

    localparam int RX_MAX = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TX_MAX = CLK_FREQ / BAUD;
    localparam int RX_W   = (RX_MAX > 1) ? $clog2(RX_MAX) : 1;
    localparam int TX_W   = (TX_MAX > 1) ? $clog2(TX_MAX) : 1;

    localparam logic [RX_W-1:0] RX_LAST = RX_W'(RX_MAX - 1);

    if (RX_MAX < 2) begin : g_bad_rx_max
        $error("baud_rate: RX_MAX must be >= 2");
    end
    if (TX_MAX < 2) begin : g_bad_tx_max
        $error("baud_rate: TX_MAX must be >= 2");
    end

    logic [RX_W-1:0] rx_cnt;
    logic            rx_wrap;

    assign rx_wrap = (rx_cnt == RX_LAST);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt   <= '0;
            Rxclk_en <= 1'b0;
        end else if (rx_wrap) begin
            rx_cnt   <= '0;
            Rxclk_en <= 1'b1;
        end else begin
            rx_cnt   <= rx_cnt + RX_W'(1);
            Rxclk_en <= 1'b0;
        end
    end

`ifdef BAUD_TX_LOCK_EN
    localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    logic [OS_W-1:0] os_cnt;

    // Counts receiver wraps so the Tx strobe lands on every OVERSAMPLE-th Rx strobe.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            os_cnt   <= '0;
            Txclk_en <= 1'b0;
        end else begin
            Txclk_en <= 1'b0;
            if (rx_wrap) begin
                if (os_cnt == OS_LAST) begin
                    os_cnt   <= '0;
                    Txclk_en <= 1'b1;
                end else begin
                    os_cnt <= os_cnt + OS_W'(1);
                end
            end
        end
    end
`else
    localparam logic [TX_W-1:0] TX_LAST = TX_W'(TX_MAX - 1);

    logic [TX_W-1:0] tx_cnt;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt   <= '0;
            Txclk_en <= 1'b0;
        end else if (tx_cnt == TX_LAST) begin
            tx_cnt   <= '0;
            Txclk_en <= 1'b1;
        end else begin
            tx_cnt   <= tx_cnt + TX_W'(1);
            Txclk_en <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_baud_rate.sv
// Bench for baud_rate: edge-count reference model checked every cycle, plus literal cadence checks.
module tb_baud_rate;

    localparam int CLK_FREQ   = 50_000_000;
    localparam int BAUD       = 115200;
    localparam int OVERSAMPLE = 16;
    localparam int RX_P       = CLK_FREQ / (BAUD * OVERSAMPLE);
`ifdef BAUD_TX_LOCK_EN
    localparam int TX_P       = RX_P * OVERSAMPLE;
`else
    localparam int TX_P       = CLK_FREQ / BAUD;
`endif

    logic clk_50m;
    logic rst_n;
    logic Rxclk_en;
    logic Txclk_en;

    int n_total;
    int n_pass;
    int k;
    bit chk_en;

    baud_rate #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .Rxclk_en(Rxclk_en),
        .Txclk_en(Txclk_en)
    );

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    // Rising edges seen since the last reset release; the whole model hangs off this.
    always @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    function automatic logic exp_rx(input int n);
        return (n > 0) && (n % RX_P == 0);
    endfunction

    function automatic logic exp_tx(input int n);
        return (n > 0) && (n % TX_P == 0);
    endfunction

    task automatic check(input string name, input logic act, input logic req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s at k=%0d t=%0t: got %b, expected %b", name, k, $time, act, req);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    always @(negedge clk_50m) begin
        if (chk_en) begin
            check("rx_model", Rxclk_en, exp_rx(k));
            check("tx_model", Txclk_en, exp_tx(k));
        end
    end

    task automatic release_reset();
        @(negedge clk_50m);
        #3 rst_n = 1'b1;
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (k < target && guard < 20000) begin
            @(negedge clk_50m);
            guard++;
        end
        if (k != target) check_int("run_to_target", k, target);
    endtask

    initial begin
        int rx_cnt_pulses;
        int tx_cnt_pulses;
        int gap;
        n_total = 0;
        n_pass  = 0;
        chk_en  = 1'b0;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        #2 chk_en = 1'b1;
        check("reset_rx", Rxclk_en, 1'b0);
        check("reset_tx", Txclk_en, 1'b0);
        repeat (5) @(negedge clk_50m);

        // Cadence over the first 2000 clocks.
        release_reset();
        rx_cnt_pulses = 0;
        tx_cnt_pulses = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk_50m);
            if (Rxclk_en === 1'b1 && k <= 1000) rx_cnt_pulses++;
            if (Txclk_en === 1'b1) tx_cnt_pulses++;
            if (k == 26) check("rx_not_early", Rxclk_en, 1'b0);
            if (k == 27) check("rx_first_27", Rxclk_en, 1'b1);
            if (k == 28) check("rx_one_wide", Rxclk_en, 1'b0);
            if (k == 54) check("rx_second_54", Rxclk_en, 1'b1);
`ifdef BAUD_TX_LOCK_EN
            if (k == 432) check("tx_lock_432", Txclk_en & Rxclk_en, 1'b1);
            if (k == 864) check("tx_lock_864", Txclk_en & Rxclk_en, 1'b1);
            if (k == 434) check("tx_lock_not_434", Txclk_en, 1'b0);
`else
            if (k == 434)  check("tx_first_434", Txclk_en, 1'b1);
            if (k == 435)  check("tx_one_wide", Txclk_en, 1'b0);
            if (k == 1736) check("tx_fourth_1736", Txclk_en, 1'b1);
`endif
        end
        check_int("rx_pulses_in_1000", rx_cnt_pulses, 37);
        check_int("tx_pulses_in_2000", tx_cnt_pulses, 4);

`ifndef BAUD_TX_LOCK_EN
        // Both strobes coincide at lcm(27,434).
        run_to(11718);
        check("coincide_11718", Rxclk_en & Txclk_en, 1'b1);
        run_to(11718 + 27);
        check("rx_after_coincide", Rxclk_en, 1'b1);
`endif

        // Mid-count reset must discard the partial period.
        rst_n = 1'b0;
        repeat (2) @(negedge clk_50m);
        release_reset();
        run_to(15);
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
        gap = 0;
        do begin
            @(negedge clk_50m);
            gap++;
        end while (Rxclk_en !== 1'b1 && gap < 100);
        check_int("rx_gap_after_midreset", gap, 27);

        // Asynchronous reset drops an active strobe before the next edge.
        run_to(54);
        check("rx_high_before_async", Rxclk_en, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("async_drop_rx", Rxclk_en, 1'b0);
        check("async_drop_tx", Txclk_en, 1'b0);
        repeat (3) @(negedge clk_50m);
        release_reset();

        // Random run lengths and reset pulses at random sub-cycle offsets.
        for (int r = 0; r < 20; r++) begin
            repeat ($urandom_range(1, 600)) @(negedge clk_50m);
            #($urandom_range(1, 8)) rst_n = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk_50m);
            @(negedge clk_50m);
            #($urandom_range(1, 8)) rst_n = 1'b1;
        end
        repeat (TX_P + 5) @(negedge clk_50m);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
